// File: rtl/cfg_frame_pkg.sv
// rtl/cfg_frame_pkg.sv - shared types and constants for the frame configuration writer
package cfg_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    SETUP,
    STROBE,
    HOLD
  } cfgState_t;

  localparam logic [3:0] OP_WRITE  = 4'h1;
  localparam logic [3:0] OP_DESYNC = 4'hF;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int IDX_MSB = 7;
  localparam int IDX_LSB = 0;
  localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

endpackage

// File: rtl/frame_strobe_decoder.sv
// rtl/frame_strobe_decoder.sv - one-hot frame latch enable from a frame index
module frame_strobe_decoder #(
  parameter int MaxFramesPerCol = 20,
  parameter int IdxW            = 8
) (
  input  logic [IdxW-1:0]            frameIdx,
  input  logic                       enable,
  output logic [MaxFramesPerCol-1:0] strobe
);

  // Indices past the last frame match no bit, so the output stays all-zero.
  always_comb begin
    strobe = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      strobe[i] = enable && (frameIdx == IdxW'(i));
    end
  end

endmodule

// File: rtl/config_frame_writer.sv
// rtl/config_frame_writer.sv - bitstream parser and frame write sequencer; CFG_FRAME_COUNT_EN adds frames_written
module config_frame_writer
  import cfg_frame_pkg::*;
#(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          StrobeCycles    = 2,
  parameter logic [31:0] SyncWord        = DEFAULT_SYNC_WORD
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       synced,
  output logic                       busy,
  output logic                       err
`ifdef CFG_FRAME_COUNT_EN
  , output logic [15:0]              frames_written
`endif
);

  localparam int              CntW     = $clog2(StrobeCycles + 1);
  localparam logic [IDX_W-1:0] IdxLimit = IDX_W'(MaxFramesPerCol);

  cfgState_t              state;
  logic [IDX_W-1:0]       frameIdx;
  logic [CntW-1:0]        strobeCnt;
  logic                   accept;
  logic                   lastStrobe;
  logic                   strobeNext;
  logic [MaxFramesPerCol-1:0] strobeDecoded;
  logic [3:0]             opcode;

  assign accept     = s_valid && s_ready;
  assign opcode     = s_data[OP_MSB:OP_LSB];
  assign lastStrobe = (strobeCnt == CntW'(StrobeCycles - 1));
  // Strobe is decoded one cycle ahead so FrameStrobe itself comes from a flop.
  assign strobeNext = (state == SETUP) || ((state == STROBE) && !lastStrobe);

  frame_strobe_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .IdxW           (IDX_W)
  ) u_decoder (
    .frameIdx(frameIdx),
    .enable  (strobeNext),
    .strobe  (strobeDecoded)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      frameIdx       <= '0;
      strobeCnt      <= '0;
      s_ready        <= 1'b0;
      FrameData      <= '0;
      FrameStrobe    <= '0;
      synced         <= 1'b0;
      busy           <= 1'b0;
      err            <= 1'b0;
`ifdef CFG_FRAME_COUNT_EN
      frames_written <= '0;
`endif
    end else begin
      FrameStrobe <= strobeDecoded;
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (accept && (s_data == SyncWord)) begin
            state  <= HDR;
            synced <= 1'b1;
            err    <= 1'b0;
`ifdef CFG_FRAME_COUNT_EN
            frames_written <= '0;
`endif
          end
        end
        HDR: begin
          s_ready <= 1'b1;
          // Sync must be tested first: its top nibble aliases the DESYNC opcode.
          if (accept && (s_data != SyncWord)) begin
            if (opcode == OP_WRITE) begin
              frameIdx <= s_data[IDX_MSB:IDX_LSB];
              state    <= DATA;
            end else if (opcode == OP_DESYNC) begin
              synced <= 1'b0;
              state  <= IDLE;
            end else begin
              err    <= 1'b1;
              synced <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        DATA: begin
          if (accept) begin
            if (frameIdx >= IdxLimit) begin
              err   <= 1'b1;
              state <= HDR;
            end else begin
              FrameData <= s_data;
              s_ready   <= 1'b0;
              busy      <= 1'b1;
              strobeCnt <= '0;
              state     <= SETUP;
            end
          end
        end
        SETUP: begin
          state <= STROBE;
        end
        STROBE: begin
          if (lastStrobe) begin
            strobeCnt <= '0;
            state     <= HOLD;
`ifdef CFG_FRAME_COUNT_EN
            if (frames_written != 16'hFFFF) frames_written <= frames_written + 16'd1;
`endif
          end else begin
            strobeCnt <= strobeCnt + CntW'(1);
          end
        end
        HOLD: begin
          s_ready <= 1'b1;
          busy    <= 1'b0;
          state   <= HDR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_frame_writer.sv
// tb/tb_config_frame_writer.sv - self-checking bench for config_frame_writer
module tb_config_frame_writer;

  localparam int          FB   = 32;
  localparam int          MF   = 20;
  localparam int          SC   = 2;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic          CLK = 1'b0;
  logic          resetn = 1'b0;
  logic [FB-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [FB-1:0] FrameData;
  logic [MF-1:0] FrameStrobe;
  logic          synced;
  logic          busy;
  logic          err;
`ifdef CFG_FRAME_COUNT_EN
  logic [15:0]   frames_written;
`endif

  config_frame_writer #(
    .FrameBitsPerRow(FB),
    .MaxFramesPerCol(MF),
    .StrobeCycles   (SC),
    .SyncWord       (SYNC)
  ) dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .synced     (synced),
    .busy       (busy),
    .err        (err)
`ifdef CFG_FRAME_COUNT_EN
    , .frames_written(frames_written)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [FB-1:0] fd;
    logic [MF-1:0] fs;
  } sbEntry_t;

  typedef struct {
    logic [31:0]   hdr;
    logic [31:0]   data;
    logic [MF-1:0] fs;
  } vec_t;

  sbEntry_t sbQ[$];
  vec_t     vecs[5];
  int       nCompared = 0;
  int       nMismatched = 0;
  logic [FB-1:0] expFd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor: each pulse start pops one expected write, each pulse end checks its length.
  logic [MF-1:0] prevStrobe = '0;
  int            runLen = 0;
  always @(negedge CLK) begin
    if (!resetn) begin
      prevStrobe = '0;
      runLen     = 0;
    end else begin
      if (FrameStrobe != '0) begin
        check("strobe_onehot", 64'($countones(FrameStrobe)), 64'd1);
        if (prevStrobe == '0) begin
          if (sbQ.size() == 0) begin
            check("unexpected_strobe", 64'(FrameStrobe), 64'd0);
          end else begin
            sbEntry_t e;
            e = sbQ.pop_front();
            check("sb_strobe", 64'(FrameStrobe), 64'(e.fs));
            check("sb_framedata", 64'(FrameData), 64'(e.fd));
          end
        end
        runLen++;
      end else if (prevStrobe != '0) begin
        check("strobe_len", 64'(runLen), 64'(SC));
        runLen = 0;
      end
      prevStrobe = FrameStrobe;
    end
  end

  task automatic sendWord(input logic [31:0] w, input bit stall);
    int n;
    if (stall) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge CLK);
        s_valid = 1'b0;
        s_data  = $urandom;
      end
    end
    @(negedge CLK);
    s_valid = 1'b1;
    s_data  = w;
    n = 0;
    while (!s_ready && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!s_ready) begin
      check("handshake_timeout", 64'd0, 64'd1);
      s_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    #1 s_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge CLK);
    while (!(s_ready && !busy) && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!(s_ready && !busy)) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic doWrite(input logic [31:0] hdr, input logic [31:0] data,
                         input logic [MF-1:0] fs, input bit stall);
    if (fs != '0) begin
      sbQ.push_back('{fd: data, fs: fs});
      expFd = data;
    end
    sendWord(hdr, stall);
    sendWord(data, stall);
    waitIdle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{hdr: 32'h1000_0000, data: 32'h0000_0001, fs: 20'h00001};
    vecs[1] = '{hdr: 32'h1000_0013, data: 32'hFFFF_FFFF, fs: 20'h80000};
    vecs[2] = '{hdr: 32'h10FF_FF05, data: 32'h1234_5678, fs: 20'h00020};
    vecs[3] = '{hdr: 32'h1000_000A, data: 32'hA5A5_5A5A, fs: 20'h00400};
    vecs[4] = '{hdr: 32'h1000_0019, data: 32'hCAFE_F00D, fs: 20'h00000};
    expFd = '0;

    // 1: reset values, then sync
    repeat (3) @(negedge CLK);
    check("rst_framedata", 64'(FrameData), 64'd0);
    check("rst_strobe", 64'(FrameStrobe), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd0);
    check("rst_synced", 64'(synced), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
`ifdef CFG_FRAME_COUNT_EN
    check("rst_count", 64'(frames_written), 64'd0);
`endif
    resetn = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("idle_ready", 64'(s_ready), 64'd1);
    sendWord(SYNC, 1'b0);
    @(negedge CLK);
    check("synced_after_sync", 64'(synced), 64'd1);
    check("sync_strobe", 64'(FrameStrobe), 64'd0);

    // 2: single write with exact phase timing; a repeated sync in HDR is ignored
    sendWord(SYNC, 1'b0);
    sbQ.push_back('{fd: 32'hDEAD_BEEF, fs: 20'h00008});
    expFd = 32'hDEAD_BEEF;
    sendWord(32'h1000_0003, 1'b0);
    sendWord(32'hDEAD_BEEF, 1'b0);
    @(negedge CLK);
    check("setup_framedata", 64'(FrameData), 64'hDEAD_BEEF);
    check("setup_strobe", 64'(FrameStrobe), 64'd0);
    check("setup_ready", 64'(s_ready), 64'd0);
    check("setup_busy", 64'(busy), 64'd1);
    @(negedge CLK);
    check("strobe1", 64'(FrameStrobe), 64'h8);
    check("strobe1_ready", 64'(s_ready), 64'd0);
    @(negedge CLK);
    check("strobe2", 64'(FrameStrobe), 64'h8);
    check("strobe2_ready", 64'(s_ready), 64'd0);
    @(negedge CLK);
    check("hold_strobe", 64'(FrameStrobe), 64'd0);
    check("hold_ready", 64'(s_ready), 64'd0);
    check("hold_framedata", 64'(FrameData), 64'hDEAD_BEEF);
    @(negedge CLK);
    check("post_ready", 64'(s_ready), 64'd1);
    check("post_busy", 64'(busy), 64'd0);

    // table of writes, including field extraction and the frame index limits
    for (int i = 0; i < 5; i++) begin
      doWrite(vecs[i].hdr, vecs[i].data, vecs[i].fs, 1'b0);
      check($sformatf("vec%0d_framedata", i), 64'(FrameData), 64'(expFd));
      check($sformatf("vec%0d_err", i), 64'(err), (vecs[i].fs == '0) ? 64'd1 : 64'd0);
    end

    // 3: index 20 is out of range; the next header is still accepted
    sendWord(32'h1000_0014, 1'b0);
    sendWord(32'h0BAD_0BAD, 1'b0);
    @(negedge CLK);
    check("oor_err", 64'(err), 64'd1);
    check("oor_framedata", 64'(FrameData), 64'(expFd));
    check("oor_ready", 64'(s_ready), 64'd1);
    check("oor_busy", 64'(busy), 64'd0);
    doWrite(32'h1000_0001, 32'h0000_00AA, 20'h00002, 1'b0);
    check("oor_next_framedata", 64'(FrameData), 64'hAA);

    // 4: bad opcode, discard in IDLE, re-sync, desync
    sendWord(32'h7000_0000, 1'b0);
    @(negedge CLK);
    check("badop_err", 64'(err), 64'd1);
    check("badop_synced", 64'(synced), 64'd0);
    sendWord(32'h1000_0002, 1'b0);
    sendWord(32'h5555_5555, 1'b0);
    @(negedge CLK);
    check("idle_discard_framedata", 64'(FrameData), 64'hAA);
    sendWord(SYNC, 1'b0);
    @(negedge CLK);
    check("resync_err", 64'(err), 64'd0);
    check("resync_synced", 64'(synced), 64'd1);
    sendWord(32'hF000_0000, 1'b0);
    @(negedge CLK);
    check("desync_synced", 64'(synced), 64'd0);

    // 5: the table again with random valid stalls
    sendWord(SYNC, 1'b1);
    for (int i = 0; i < 5; i++) begin
      doWrite(vecs[i].hdr, vecs[i].data, vecs[i].fs, 1'b1);
      check($sformatf("stall%0d_framedata", i), 64'(FrameData), 64'(expFd));
    end

    // reset asserted while the strobe is high
    sbQ.push_back('{fd: 32'h0123_4567, fs: 20'h00010});
    sendWord(32'h1000_0004, 1'b0);
    sendWord(32'h0123_4567, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    check("midrst_pre_strobe", 64'(FrameStrobe), 64'h10);
    #2 resetn = 1'b0;
    #1;
    check("midrst_strobe", 64'(FrameStrobe), 64'd0);
    check("midrst_framedata", 64'(FrameData), 64'd0);
    check("midrst_ready", 64'(s_ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_synced", 64'(synced), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    repeat (2) @(negedge CLK);
    resetn = 1'b1;
    expFd = '0;

`ifdef CFG_FRAME_COUNT_EN
    // 6: three good writes and one errored write, then clear on re-sync
    sendWord(SYNC, 1'b0);
    doWrite(32'h1000_0000, 32'h1111_1111, 20'h00001, 1'b0);
    doWrite(32'h1000_0007, 32'h2222_2222, 20'h00080, 1'b0);
    doWrite(32'h1000_0030, 32'h3333_3333, 20'h00000, 1'b0);
    doWrite(32'h1000_0012, 32'h4444_4444, 20'h40000, 1'b0);
    check("count_three", 64'(frames_written), 64'd3);
    sendWord(32'hF000_0000, 1'b0);
    sendWord(SYNC, 1'b0);
    @(negedge CLK);
    check("count_cleared", 64'(frames_written), 64'd0);
`endif

    repeat (4) @(negedge CLK);
    check("sb_drained", 64'(sbQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
